alu_control_unit: RTL and testbench
===================================

ALU_CONTROL_UNIT -- requirements
Module: alu_control

Interface
REQ-001 The module SHALL have parameter CODE_W, default 3, meaning width of the ALU control code; only 3 is supported.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port alu_op, input, 2, main-decoder operation class.
REQ-005 The module SHALL have port function_input, input, 3, instruction function field.
REQ-006 The module SHALL have port in_valid, input, 1, qualifies alu_op and function_input for sampling.
REQ-007 The module SHALL have port alu_control, output, 3, registered ALU operation code.
REQ-008 The module SHALL have port out_valid, output, 1, alu_control holds a fresh decode this cycle.
REQ-009 The module SHALL have port illegal, output, 1, registered flag for an illegal alu_op/function_input pair (ALU_CTRL_ILLEGAL_CHK_EN only).
REQ-010 The module SHALL have port illegal_cnt, output, 8, saturating count of illegal decodes (ALU_CTRL_ILLEGAL_CHK_EN only).

Function
REQ-011 The module SHALL use alu_control encoding 000 ADD, 001 SUB, 010 SLT, 011 AND, 100 OR, 101 XOR, 110 SLL, 111 SRL.
REQ-012 alu_op 00 (load/store) SHALL decode to ADD (000) whatever function_input is.
REQ-013 alu_op 01 (branch) SHALL decode to SUB (001) whatever function_input is.
REQ-014 alu_op 10 (register type) SHALL decode to alu_control = function_input unchanged; every value is legal.
REQ-015 alu_op 11 (immediate type) SHALL decode function_input 000 ADD, 010 SLT, 011 AND, 100 OR, 101 XOR, 110 SLL, 111 SRL.
REQ-016 alu_op 11 with function_input 001 SHALL be illegal and SHALL decode to ADD (000).
REQ-017 When in_valid is 1 at a rising clk edge, the decode SHALL be registered into alu_control with out_valid 1 in the next cycle; latency is exactly one cycle.
REQ-018 When in_valid is 0 at a rising edge, alu_control SHALL hold its previous value and out_valid SHALL be 0.
REQ-019 Back-to-back in_valid SHALL give one result per cycle, with no bubbles and no backpressure.
REQ-020 illegal SHALL be registered alongside alu_control and SHALL be 0 whenever out_valid is 0.
REQ-021 illegal_cnt SHALL increment by one for each registered illegal decode and SHALL saturate at 255 without wrapping.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear alu_control to 000, out_valid to 0, illegal to 0 and illegal_cnt to 0, independent of clk.
REQ-023 A decode in flight when reset asserts SHALL be discarded; after release, the first in_valid produces out_valid one cycle later.

Configuration
REQ-024 Macro ALU_CTRL_ILLEGAL_CHK_EN defined SHALL enable illegal detection, the illegal flag and illegal_cnt per REQ-016, REQ-020 and REQ-021.
REQ-025 Without ALU_CTRL_ILLEGAL_CHK_EN, illegal and illegal_cnt SHALL be tied to 0 and no counter logic SHALL exist; the decode of REQ-016 still yields ADD.

Structure
REQ-026 A shared package alu_pkg SHALL hold the alu_control code constants, the alu_op class constants and the immediate function-field constants.
REQ-027 The combinational decode SHALL reside in sub-module alu_control_decode (inputs alu_op and function_input; outputs code and illegal), and alu_control SHALL add the registers, valid logic and counter.

Verification
REQ-028 alu_op 00 with function_input 000, then 010, each with in_valid 1 -> alu_control 000 and out_valid 1, one cycle later for each.
REQ-029 alu_op 01 with function_input 000, then 010 -> alu_control 001 for both.
REQ-030 alu_op 10 with function_input 000, then 010 -> alu_control 000, then 010; a sweep of all 8 values -> code equals function_input.
REQ-031 alu_op 11 with function_input 001, repeated 300 cycles with the macro defined -> alu_control 000, illegal 1, illegal_cnt saturates at 255; with the macro undefined -> illegal and illegal_cnt remain 0.
REQ-032 rst_n pulsed low mid-stream, asynchronously between clk edges -> all outputs 0 immediately; with in_valid 0 -> out_valid 0 and alu_control holds.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control code, alu_op class and immediate function-field constants
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLT = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_code_e;

  typedef enum logic [1:0] {
    OP_LDST   = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_ITYPE  = 2'b11
  } alu_op_e;

  // Immediate-type function field; 001 has no immediate form and is reserved.
  localparam logic [2:0] FN_ADDI = 3'b000;
  localparam logic [2:0] FN_RSVD = 3'b001;
  localparam logic [2:0] FN_SLTI = 3'b010;
  localparam logic [2:0] FN_ANDI = 3'b011;
  localparam logic [2:0] FN_ORI  = 3'b100;
  localparam logic [2:0] FN_XORI = 3'b101;
  localparam logic [2:0] FN_SLLI = 3'b110;
  localparam logic [2:0] FN_SRLI = 3'b111;

endpackage

// File: rtl/alu_control_decode.sv
// rtl/alu_control_decode.sv - combinational alu_op/function_input to ALU code decode
// The illegal output exists only when ALU_CTRL_ILLEGAL_CHK_EN is defined.
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] function_input,
  output logic [2:0] code
`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  ,
  output logic       illegal
`endif
);

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      OP_LDST:   code = ALU_ADD;
      OP_BRANCH: code = ALU_SUB;
      OP_RTYPE:  code = function_input;
      OP_ITYPE: begin
        case (function_input)
          FN_ADDI: code = ALU_ADD;
          FN_RSVD: code = ALU_ADD;
          FN_SLTI: code = ALU_SLT;
          FN_ANDI: code = ALU_AND;
          FN_ORI:  code = ALU_OR;
          FN_XORI: code = ALU_XOR;
          FN_SLLI: code = ALU_SLL;
          FN_SRLI: code = ALU_SRL;
          default: code = ALU_ADD;
        endcase
      end
      default:   code = ALU_ADD;
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  assign illegal = (alu_op == OP_ITYPE) && (function_input == FN_RSVD);
`endif

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - registered ALU control decode with valid and illegal tracking
// Define ALU_CTRL_ILLEGAL_CHK_EN to enable the illegal flag and saturating illegal_cnt.
module alu_control_unit
  import alu_pkg::*;
#(
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        function_input,
  input  logic              in_valid,
  output logic [CODE_W-1:0] alu_control,
  output logic              out_valid,
  output logic              illegal,
  output logic [7:0]        illegal_cnt
);

  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  logic       w_illegal;
  logic       r_illegal;
  logic [7:0] r_illegal_cnt;

  alu_control_decode u_decode (
    .alu_op         (alu_op),
    .function_input (function_input),
    .code           (w_code),
    .illegal        (w_illegal)
  );
`else
  alu_control_decode u_decode (
    .alu_op         (alu_op),
    .function_input (function_input),
    .code           (w_code)
  );
`endif

  // alu_control holds across idle cycles; only out_valid marks a fresh decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_code <= w_code;
      end
    end
  end

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal     <= 1'b0;
      r_illegal_cnt <= 8'd0;
    end else begin
      r_illegal <= in_valid && w_illegal;
      if (in_valid && w_illegal && (r_illegal_cnt != 8'hFF)) begin
        r_illegal_cnt <= r_illegal_cnt + 8'd1;
      end
    end
  end

  assign illegal     = r_illegal;
  assign illegal_cnt = r_illegal_cnt;
`else
  assign illegal     = 1'b0;
  assign illegal_cnt = 8'd0;
`endif

  assign alu_control = r_code;
  assign out_valid   = r_valid;

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - scoreboard bench for alu_control_unit
// Honours ALU_CTRL_ILLEGAL_CHK_EN when predicting illegal and illegal_cnt.
module tb_alu_control_unit;

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] alu_op = 2'b00;
  logic [2:0] function_input = 3'b000;
  logic       in_valid = 1'b0;
  logic [2:0] alu_control;
  logic       out_valid;
  logic       illegal;
  logic [7:0] illegal_cnt;

  typedef struct {
    logic       valid;
    logic [2:0] code;
    logic       ill;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [2:0] m_code = 3'b000;
  logic [7:0] m_cnt = 8'd0;

  alu_control_unit #(.CODE_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_op         (alu_op),
    .function_input (function_input),
    .in_valid       (in_valid),
    .alu_control    (alu_control),
    .out_valid      (out_valid),
    .illegal        (illegal),
    .illegal_cnt    (illegal_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_code(input logic [1:0] op, input logic [2:0] fn);
    case (op)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return fn;
      default: return (fn == 3'b001) ? 3'b000 : fn;
    endcase
  endfunction

  // Called on a falling edge: drive inputs, predict the next registered state, wait one cycle.
  task automatic drive(input logic [1:0] op, input logic [2:0] fn, input logic v);
    exp_t e;
    alu_op = op;
    function_input = fn;
    in_valid = v;
    e.valid = v;
    e.ill = 1'b0;
    if (v) begin
      m_code = ref_code(op, fn);
      e.ill = CHK && (op == 2'b11) && (fn == 3'b001);
      if (e.ill && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    e.code = m_code;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (alu_control !== 3'b000 || out_valid !== 1'b0 || illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: got code=%b v=%b ill=%b cnt=%0d, want all zero", alu_control, out_valid, illegal, illegal_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_store;
    exp_t e;
    logic [2:0] fns[2] = '{3'b000, 3'b010};
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, fns[i], 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL load_store: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_branch;
    exp_t e;
    logic [2:0] fns[2] = '{3'b000, 3'b010};
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, fns[i], 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL branch: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_rtype_sweep;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 3'(i), 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL rtype_%0d: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 i, out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_itype;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 3'(i), 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL itype_%0d: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 i, out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_hold;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(2'b10, 3'b011, 1'b1);
      else drive(2'b11, 3'b001, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL hold_%0d: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 i, out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 i, out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  task automatic test_illegal_saturate;
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      drive(2'b11, 3'b001, 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL illegal_%0d: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 i, out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
    n_tests++;
    if (illegal_cnt !== (CHK ? 8'hFF : 8'h00) || alu_control !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_saturated: got cnt=%0d code=%b, want cnt=%0d code=000",
               illegal_cnt, alu_control, CHK ? 255 : 0);
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    drive(2'b11, 3'b001, 1'b1);
    void'(exp_q.pop_front());
    // A decode is in flight when reset drops between clock edges.
    alu_op = 2'b10;
    function_input = 3'b110;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (alu_control !== 3'b000 || out_valid !== 1'b0 || illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got code=%b v=%b ill=%b cnt=%0d, want all zero", alu_control, out_valid, illegal, illegal_cnt);
    end
    @(negedge clk);
    n_tests++;
    if (alu_control !== 3'b000 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: got code=%b v=%b, want code=000 v=0", alu_control, out_valid);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    m_code = 3'b000;
    m_cnt = 8'd0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(2'b01, 3'b111, 1'b1);
      else drive(2'b10, 3'b101, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (out_valid !== e.valid || alu_control !== e.code || illegal !== e.ill || illegal_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL post_reset_%0d: got v=%b code=%b ill=%b cnt=%0d, want v=%b code=%b ill=%b cnt=%0d",
                 i, out_valid, alu_control, illegal, illegal_cnt, e.valid, e.code, e.ill, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_branch();
    test_rtype_sweep();
    test_itype();
    test_hold();
    test_back_to_back();
    test_illegal_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
